i2c_slave_byte_if: RTL
======================

Name: i2c_slave_byte_if

Overview:
- I2C target (slave) byte engine: the responder side paired with the team's i2c_bit_shift master.
- Oversamples SCL/SDA on the system clock and detects START, repeated START and STOP.
- Matches a 7-bit address, ACKs it, then receives write bytes or transmits read bytes through a simple byte handshake to user logic.
- Sits between the board-level open-drain pins and register-file or EEPROM-model logic.

Parameters:
- SLAVE_ADDR, 7'h50, 7-bit device address matched in the first byte after START.
- DATA_WIDTH, 8, byte width. Fixed at 8 by the protocol; the parameter exists for port sizing only.
- SYNC_STAGES, 2, flip-flop stages on the SCL and SDA inputs (minimum 2).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  reset, synchronous, active-low.
- i2c_sclk  input  1  bus clock from the master.
- i2c_sda  inout  1  open-drain data line. Drives 1'b0 or 1'bz only, never 1.
- rx_data  output  8  last received write byte; held until the next byte completes.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- rx_ready  input  1  sampled at byte end. 1 = ACK the byte, 0 = NACK it.
- tx_data  input  8  next read byte; must be stable before tx_pop.
- tx_pop  output  1  one-clk pulse; tx_data is captured on this cycle.
- rw  output  1  R/W bit of the current transaction.
- addr_match  output  1  one-clk pulse when the address matches.
- ack_o  output  1  master ACK level sampled after each read byte (0 = ACK).
- start_det  output  1  one-clk pulse on START or repeated START.
- stop_det  output  1  one-clk pulse on STOP.
- busy  output  1  high from address match until STOP, NACK-end or mismatch.

Behaviour:
- Reset values (rst_n low at posedge clk): SDA released (z); rx_data=0; rx_valid=0; tx_pop=0; rw=0; addr_match=0; ack_o=1; start_det=0; stop_det=0; busy=0; FSM=IDLE.
- Input conditioning: SCL and SDA each pass through SYNC_STAGES flops, then a 1-clk-delayed copy gives the edge detects (scl_rise, scl_fall).
- START: SDA falls while synced SCL is high.
- STOP: SDA rises while synced SCL is high.
- Timing assumption: SYS_CLK/SCL ≥ 16.
- Sampling and drive points: SDA is sampled on scl_rise. The drive state changes only on scl_fall, with latency SYNC_STAGES+1 clks, which stays inside tHD;DAT at 400 kHz / 50 MHz.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- START or repeated START, from any state (including IDLE): go to ADDR, clear the bit counter, release SDA, pulse start_det.
- STOP, from any state: go to IDLE, release SDA, clear busy, pulse stop_det.
- ADDR: shift in 8 bits MSB first on scl_rise. After bit 8:
  - match (byte[7:1]==SLAVE_ADDR): latch rw=byte[0], pulse addr_match, set busy. On the next scl_fall drive SDA low and enter ADDR_ACK.
  - mismatch: go to IDLE and never drive SDA.
- ADDR_ACK: release SDA on the scl_fall ending the 9th clock. Then:
  - rw=0: enter WR_DATA.
  - rw=1: pulse tx_pop, load the shift register from tx_data, drive bit7 (low = drive 0, high = z) and enter RD_DATA.
- WR_DATA: after the 8th scl_rise, update rx_data, pulse rx_valid and sample rx_ready. On the next scl_fall drive SDA low if rx_ready=1 (else leave it released) and enter WR_ACK.
- WR_ACK: release SDA on scl_fall.
  - If the byte was ACKed, go back to WR_DATA.
  - If it was NACKed, go to IDLE and clear busy.
- RD_DATA: present the next bit on each scl_fall. After the 8th bit's scl_fall, release SDA and enter RD_ACK.
- RD_ACK: sample SDA into ack_o on scl_rise.
  - ack_o=0: on scl_fall pulse tx_pop, load the next byte, drive its bit7 and enter RD_DATA.
  - ack_o=1: go to IDLE, clear busy, keep SDA released.
- Simultaneous-event priority: STOP and START detection win over any bit processing in the same clk.
- Edge-ordering rule: a START/STOP condition can never coincide with scl_rise/scl_fall, since SCL is high and stable when they occur.
- Reset mid-transfer: go to IDLE immediately and release SDA. Bus activity is ignored until the next START.
- Not supported: general call, 10-bit addressing, clock stretching.

Test Plan:
- Write transaction (rx_ready=1): START, 0xA0, 0x3C, STOP → ACK (SDA=0) in the 9th slot of both bytes; rx_data=0x3C; exactly one rx_valid; rw=0; addr_match once; stop_det once; busy returns to 0.
- Address mismatch: START, 0xA2, 0x55, STOP → SDA never driven; no addr_match, no rx_valid; busy stays 0; start_det and stop_det still pulse.
- Read transaction: START, 0xA1; tx_data 0xA5, then 0x5A after the first pop; master ACKs byte 1 and NACKs byte 2, then STOP → SDA bit streams 10100101 and 01011010; two tx_pop pulses; ack_o=0 after byte 1 and 1 after byte 2; rw=1.
- Write refused: rx_ready=0 during byte 0x77 after address 0xA0 → the 9th slot stays high (z via pullup); FSM returns to IDLE; a following 0x11 is not captured.
- Repeated START: after bit 4 of a write byte, issue Sr with 0xA1 → bit counter clears; address ACKed; rw=1; the partial byte never raises rx_valid.
- Reset mid-read: assert rst_n=0 for 2 clks during bit 3 of read byte 0x00 → SDA is z the clk after reset; outputs return to reset values; the remaining SCL pulses are ignored until the next START.

Source files
------------

// File: rtl/i2c_slave_byte_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_slave_byte_if
// Description : I2C target byte engine. Oversamples SCL/SDA, detects START,
//               repeated START and STOP, matches a 7-bit address and moves
//               write/read bytes through a simple handshake to user logic.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_slave_byte_if #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         DATA_WIDTH  = 8,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i2c_sclk,
  inout  wire                   i2c_sda,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_pop,
  output logic                  rw,
  output logic                  addr_match,
  output logic                  ack_o,
  output logic                  start_det,
  output logic                  stop_det,
  output logic                  busy
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_ADDR     = 3'd1;
  localparam logic [2:0] S_ADDR_ACK = 3'd2;
  localparam logic [2:0] S_WR_DATA  = 3'd3;
  localparam logic [2:0] S_WR_ACK   = 3'd4;
  localparam logic [2:0] S_RD_DATA  = 3'd5;
  localparam logic [2:0] S_RD_ACK   = 3'd6;

  localparam logic [3:0] c_LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic [3:0] c_FULL     = 4'(DATA_WIDTH);

  // Synchronizer stages plus one extra delayed copy for edge detection.
  logic [SYNC_STAGES:0] scl_pipe_q;
  logic [SYNC_STAGES:0] sda_pipe_q;

  logic w_scl_s, w_scl_prev, w_sda_s, w_sda_prev;
  logic w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [DATA_WIDTH-1:0] w_byte_in;

  logic [2:0]            state_q,      state_d;
  logic [3:0]            bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q,      shift_d;
  logic                  sda_oe_q,     sda_oe_d;
  logic [DATA_WIDTH-1:0] rx_data_q,    rx_data_d;
  logic                  rx_valid_q,   rx_valid_d;
  logic                  tx_pop_q,     tx_pop_d;
  logic                  rw_q,         rw_d;
  logic                  addr_match_q, addr_match_d;
  logic                  ack_o_q,      ack_o_d;
  logic                  start_det_q,  start_det_d;
  logic                  stop_det_q,   stop_det_d;
  logic                  busy_q,       busy_d;
  logic                  wr_ack_q,     wr_ack_d;

  // Input conditioning; left unreset so a reset released mid-transfer cannot
  // manufacture a START/STOP out of stale pipeline contents.
  always_ff @(posedge clk) begin
    scl_pipe_q <= {scl_pipe_q[SYNC_STAGES-1:0], i2c_sclk};
    sda_pipe_q <= {sda_pipe_q[SYNC_STAGES-1:0], i2c_sda};
  end

  assign w_scl_s    = scl_pipe_q[SYNC_STAGES-1];
  assign w_scl_prev = scl_pipe_q[SYNC_STAGES];
  assign w_sda_s    = sda_pipe_q[SYNC_STAGES-1];
  assign w_sda_prev = sda_pipe_q[SYNC_STAGES];

  assign w_scl_rise = w_scl_s & ~w_scl_prev;
  assign w_scl_fall = ~w_scl_s & w_scl_prev;
  assign w_start    = w_scl_s & w_scl_prev & w_sda_prev & ~w_sda_s;
  assign w_stop     = w_scl_s & w_scl_prev & ~w_sda_prev & w_sda_s;
  assign w_byte_in  = {shift_q[DATA_WIDTH-2:0], w_sda_s};

  // Protocol FSM next-state: bus conditions first, then bit-level work.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rw_d         = rw_q;
    ack_o_d      = ack_o_q;
    busy_d       = busy_q;
    wr_ack_d     = wr_ack_q;
    rx_valid_d   = 1'b0;
    tx_pop_d     = 1'b0;
    addr_match_d = 1'b0;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;

    if (w_start) begin
      state_d     = S_ADDR;
      bit_cnt_d   = 4'd0;
      sda_oe_d    = 1'b0;
      start_det_d = 1'b1;
    end else if (w_stop) begin
      state_d    = S_IDLE;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: ;
        S_ADDR: begin
          if (w_scl_rise && bit_cnt_q != c_FULL) begin
            shift_d   = w_byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == c_LAST_BIT) begin
              if (w_byte_in[7:1] == SLAVE_ADDR) begin
                rw_d         = w_byte_in[0];
                addr_match_d = 1'b1;
                busy_d       = 1'b1;
              end else begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
              end
            end
          end else if (w_scl_fall && bit_cnt_q == c_FULL) begin
            sda_oe_d = 1'b1;
            state_d  = S_ADDR_ACK;
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (rw_q) begin
              tx_pop_d  = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[DATA_WIDTH-1];
              bit_cnt_d = 4'd1;
              state_d   = S_RD_DATA;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = S_WR_DATA;
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise && bit_cnt_q != c_FULL) begin
            shift_d   = w_byte_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == c_LAST_BIT) begin
              rx_data_d  = w_byte_in;
              rx_valid_d = 1'b1;
              wr_ack_d   = rx_ready;
            end
          end else if (w_scl_fall && bit_cnt_q == c_FULL) begin
            sda_oe_d = wr_ack_q;
            state_d  = S_WR_ACK;
          end
        end
        S_WR_ACK: begin
          if (w_scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (wr_ack_q) begin
              state_d = S_WR_DATA;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end
        end
        S_RD_DATA: begin
          if (w_scl_fall) begin
            if (bit_cnt_q == c_FULL) begin
              sda_oe_d = 1'b0;
              state_d  = S_RD_ACK;
            end else begin
              shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
              sda_oe_d  = ~shift_q[DATA_WIDTH-2];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            ack_o_d = w_sda_s;
          end else if (w_scl_fall) begin
            if (!ack_o_q) begin
              tx_pop_d  = 1'b1;
              shift_d   = tx_data;
              sda_oe_d  = ~tx_data[DATA_WIDTH-1];
              bit_cnt_d = 4'd1;
              state_d   = S_RD_DATA;
            end else begin
              sda_oe_d = 1'b0;
              busy_d   = 1'b0;
              state_d  = S_IDLE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 4'd0;
      shift_q      <= '0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      tx_pop_q     <= 1'b0;
      rw_q         <= 1'b0;
      addr_match_q <= 1'b0;
      ack_o_q      <= 1'b1;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      busy_q       <= 1'b0;
      wr_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      tx_pop_q     <= tx_pop_d;
      rw_q         <= rw_d;
      addr_match_q <= addr_match_d;
      ack_o_q      <= ack_o_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      busy_q       <= busy_d;
      wr_ack_q     <= wr_ack_d;
    end
  end

  // Open-drain pin: only ever pulls low or floats.
  assign i2c_sda    = sda_oe_q ? 1'b0 : 1'bz;

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign tx_pop     = tx_pop_q;
  assign rw         = rw_q;
  assign addr_match = addr_match_q;
  assign ack_o      = ack_o_q;
  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
